sys1_video_timing: RTL and testbench
====================================

Name: sys1_video_timing

Overview:
- Generates raster timing for the SEGA System 1/2 core from the 48 MHz master clock.
- Produces the 6 MHz pixel enable and the PH/PV pixel coordinates consumed by the system top, plus sync and blanking.
- Registers the top's 8-bit POUT into blank-gated 3-3-2 RGB aligned with delayed sync/blank for the scan converter/VGA encoder.
- Provides screen-centering offsets, latched once per frame.

Parameters:
H_TOTAL, 384, pixels per line (PH counts 0..H_TOTAL-1)
H_ACTIVE, 256, visible pixels (PH 0..H_ACTIVE-1)
HS_START, 288, nominal HSYNC assert pixel
HS_WIDTH, 32, HSYNC width in pixels
V_TOTAL, 264, lines per frame
V_ACTIVE, 224, visible lines (PV 0..V_ACTIVE-1)
VS_START, 236, nominal VSYNC assert line
VS_WIDTH, 3, VSYNC width in lines

Ports:
clk48M  in  1  master clock; the block's only clock
reset  in  1  synchronous, active-high reset
HOFS  in  4  signed horizontal sync offset, -8..+7 pixels
VOFS  in  4  signed vertical sync offset, -8..+7 lines
POUT  in  8  pixel from system top: [2:0]=R, [5:3]=G, [7:6]=B
CE_PIX  out  1  one-cycle pixel enable, 1 of every 8 clk48M cycles
PH  out  9  current pixel column
PV  out  9  current line
HBLK  out  1  aligned horizontal blank
VBLK  out  1  aligned vertical blank
HSYNC  out  1  aligned horizontal sync, active-high
VSYNC  out  1  aligned vertical sync, active-high
R  out  3  red, forced to 0 when blanked
G  out  3  green, forced to 0 when blanked
B  out  2  blue, forced to 0 when blanked

Behaviour:
Reset:
- While reset=1: div=0, PH=0, PV=0, and all other outputs 0.
- Latched offsets = 0.

Pixel enable:
- 3-bit div increments on every clk48M edge.
- CE_PIX=1 exactly in the cycle where div==7.
- The first CE_PIX occurs 7 edges after reset is released.
- Period is exactly 8 cycles, duty 1/8.

Counters:
- PH and PV advance only on an edge where CE_PIX=1.
- PH wraps from H_TOTAL-1 to 0.
- On that wrap, PV increments; PV wraps from V_TOTAL-1 to 0.

Raw timing, combinational from the current PH/PV:
- hb = PH>=H_ACTIVE
- vb = PV>=V_ACTIVE
- hs = PH in [HS_START+hofs_l, HS_START+hofs_l+HS_WIDTH)
- vs = PV in [VS_START+vofs_l, +VS_WIDTH)
- Range arithmetic is sign-extended to 10 bits with no wrap. With the defaults the windows always stay inside the blanking interval.
- Offsets change sync position only; blanking is unaffected.

Offset latch:
- hofs_l and vofs_l load HOFS/VOFS only on the CE_PIX edge where PH=H_TOTAL-1 and PV=V_TOTAL-1 (frame wrap).
- Mid-frame changes take effect from the next frame, so sync width never glitches.

Output pipeline:
- On each CE_PIX edge, register:
  - HBLK<=hb, VBLK<=vb, HSYNC<=hs, VSYNC<=vs
  - {B,G,R} <= (hb|vb) ? 0 : {POUT[7:6],POUT[5:3],POUT[2:0]}
- Latency: 1 pixel. Outputs describe the pixel at the previous PH value.
- Between CE_PIX edges all outputs hold.

Reset mid-frame:
- Counters, div and pipeline restart from 0 immediately on the next edge.
- No partial sync pulse persists past reset.

Frame rate:
- 48e6 / 8 / (384*264) = 59.19 Hz with defaults.

Test Plan:
- Reset held 5 cycles, released -> CE_PIX first high on 7th edge after release, then every 8th cycle; PH=1 after first CE_PIX edge; PV=0.
- Run 384 CE_PIX pulses from reset -> PH=0, PV=1; HBLK rises one pixel after PH reaches 256 and falls one pixel after PH wraps to 0.
- HOFS=0: HSYNC high for exactly 32 pixels (256 clk48M cycles), rising one pixel after PH=288. HOFS=-8 at next frame -> rising after PH=280, width still 32.
- HOFS changed to +7 at PV=100 -> current frame HSYNC still at 288; from PV=0 of next frame at 295.
- VOFS=+2: VSYNC high for 3 lines, first line PV=238 (+1 pixel latency). VBLK high for PV 224..263, i.e. 40 lines; frame length 101376 CE_PIX pulses.
- POUT=8'hFF during active area -> R=7, G=7, B=3; same POUT at PH=300 or PV=230 -> RGB=0. Reset asserted at PH=150, PV=50 -> all outputs 0 next edge, PH=PV=0.

Source files
------------

// File: rtl/sys1_video_timing.sv
// sys1_video_timing: SEGA System 1/2 raster timing, 6 MHz pixel enable and blank-gated RGB pipeline
// Sync offsets are latched at the frame wrap so a sync pulse never changes width mid-frame.
module sys1_video_timing #(
    parameter int H_TOTAL  = 384,
    parameter int H_ACTIVE = 256,
    parameter int HS_START = 288,
    parameter int HS_WIDTH = 32,
    parameter int V_TOTAL  = 264,
    parameter int V_ACTIVE = 224,
    parameter int VS_START = 236,
    parameter int VS_WIDTH = 3
) (
    input  logic       clk48M,
    input  logic       reset,
    input  logic [3:0] HOFS,
    input  logic [3:0] VOFS,
    input  logic [7:0] POUT,
    output logic       CE_PIX,
    output logic [8:0] PH,
    output logic [8:0] PV,
    output logic       HBLK,
    output logic       VBLK,
    output logic       HSYNC,
    output logic       VSYNC,
    output logic [2:0] R,
    output logic [2:0] G,
    output logic [1:0] B
);
    logic [2:0] r_div;
    logic [8:0] r_ph;
    logic [8:0] r_pv;
    logic [3:0] r_hofs;
    logic [3:0] r_vofs;
    logic       w_hend;
    logic       w_vend;
    logic       w_hb;
    logic       w_vb;
    logic       w_hs;
    logic       w_vs;
    logic [9:0] w_ph;
    logic [9:0] w_pv;
    logic [9:0] w_hs_lo;
    logic [9:0] w_vs_lo;

    assign CE_PIX  = r_div == 3'd7;
    assign PH      = r_ph;
    assign PV      = r_pv;
    assign w_hend  = r_ph == 9'(H_TOTAL - 1);
    assign w_vend  = r_pv == 9'(V_TOTAL - 1);
    assign w_ph    = {1'b0, r_ph};
    assign w_pv    = {1'b0, r_pv};
    assign w_hb    = r_ph >= 9'(H_ACTIVE);
    assign w_vb    = r_pv >= 9'(V_ACTIVE);
    // Windows are compared in 10 bits so a negative offset never wraps around zero.
    assign w_hs_lo = 10'(HS_START) + {{6{r_hofs[3]}}, r_hofs};
    assign w_vs_lo = 10'(VS_START) + {{6{r_vofs[3]}}, r_vofs};
    assign w_hs    = (w_ph >= w_hs_lo) && (w_ph < w_hs_lo + 10'(HS_WIDTH));
    assign w_vs    = (w_pv >= w_vs_lo) && (w_pv < w_vs_lo + 10'(VS_WIDTH));

    always_ff @(posedge clk48M) begin
        if (reset) begin
            r_div  <= 3'd0;
            r_ph   <= 9'd0;
            r_pv   <= 9'd0;
            r_hofs <= 4'd0;
            r_vofs <= 4'd0;
            HBLK   <= 1'b0;
            VBLK   <= 1'b0;
            HSYNC  <= 1'b0;
            VSYNC  <= 1'b0;
            R      <= 3'd0;
            G      <= 3'd0;
            B      <= 2'd0;
        end else begin
            r_div <= r_div + 3'd1;
            if (CE_PIX) begin
                r_ph  <= w_hend ? 9'd0 : r_ph + 9'd1;
                if (w_hend) r_pv <= w_vend ? 9'd0 : r_pv + 9'd1;
                if (w_hend && w_vend) begin
                    r_hofs <= HOFS;
                    r_vofs <= VOFS;
                end
                HBLK  <= w_hb;
                VBLK  <= w_vb;
                HSYNC <= w_hs;
                VSYNC <= w_vs;
                {B, G, R} <= (w_hb || w_vb) ? 8'd0 : POUT;
            end
        end
    end
endmodule

// File: tb/tb_sys1_video_timing.sv
// tb_sys1_video_timing: scoreboard bench for sys1_video_timing, one default-sized and one shrunken raster
// Expected output words are queued by CE_PIX edge index; the monitor compares them as those edges occur.
module tb_sys1_video_timing;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] HOFS = 4'h8;
    logic [3:0] VOFS = 4'd2;
    logic [7:0] POUT = 8'h96;

    logic       d_ce, d_hb, d_vb, d_hs, d_vs;
    logic [8:0] d_ph, d_pv;
    logic [2:0] d_r, d_g;
    logic [1:0] d_b;
    logic       s_ce, s_hb, s_vb, s_hs, s_vs;
    logic [8:0] s_ph, s_pv;
    logic [2:0] s_r, s_g;
    logic [1:0] s_b;

    typedef struct {
        int          d;
        int          k;
        logic [30:0] exp;
    } entry_t;

    entry_t sb[$];
    int n_vec  = 0;
    int n_fail = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    sys1_video_timing u_d (
        .clk48M(clk), .reset(reset), .HOFS(HOFS), .VOFS(VOFS), .POUT(POUT),
        .CE_PIX(d_ce), .PH(d_ph), .PV(d_pv), .HBLK(d_hb), .VBLK(d_vb),
        .HSYNC(d_hs), .VSYNC(d_vs), .R(d_r), .G(d_g), .B(d_b)
    );

    // Shrunken raster so several frames fit in a short run.
    sys1_video_timing #(
        .H_TOTAL(64), .H_ACTIVE(32), .HS_START(44), .HS_WIDTH(8),
        .V_TOTAL(36), .V_ACTIVE(16), .VS_START(25), .VS_WIDTH(3)
    ) u_s (
        .clk48M(clk), .reset(reset), .HOFS(HOFS), .VOFS(VOFS), .POUT(POUT),
        .CE_PIX(s_ce), .PH(s_ph), .PV(s_pv), .HBLK(s_hb), .VBLK(s_vb),
        .HSYNC(s_hs), .VSYNC(s_vs), .R(s_r), .G(s_g), .B(s_b)
    );

    task automatic push(input int d, input int k, input int ph, input int pv,
                        input bit hb, input bit vb, input bit hs, input bit vs, input logic [7:0] pout);
        entry_t e;
        e.d   = d;
        e.k   = k;
        e.exp = {1'b0, 9'(ph), 9'(pv), hb, vb, hs, vs, (hb | vb) ? 8'd0 : pout};
        sb.push_back(e);
    endtask

    task automatic check(input int k);
        logic [30:0] got;
        for (int i = 0; i < sb.size();) begin
            if (sb[i].k == k) begin
                got = sb[i].d == 0 ? {d_ce, d_ph, d_pv, d_hb, d_vb, d_hs, d_vs, d_b, d_g, d_r}
                                   : {s_ce, s_ph, s_pv, s_hb, s_vb, s_hs, s_vs, s_b, s_g, s_r};
                n_vec++;
                if (got !== sb[i].exp) begin
                    n_fail++;
                    $display("FAIL dut%0d_k%0d got=%h exp=%h (ce,ph,pv,hb,vb,hs,vs,bgr)",
                             sb[i].d, k, got, sb[i].exp);
                end
                sb.delete(i);
            end else i++;
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            cyc = 0;
            check(0);
        end else begin
            cyc++;
            if (cyc <= 24) begin
                n_vec += 2;
                if (d_ce !== (cyc % 8 == 7) || s_ce !== (cyc % 8 == 7)) begin
                    n_fail++;
                    $display("FAIL ce_pix cyc=%0d got=%b/%b exp=%b", cyc, d_ce, s_ce, cyc % 8 == 7);
                end
            end
            if (cyc % 8 == 0) check(cyc / 8);
        end
    end

    initial begin
        push(0, 0, 0, 0, 0, 0, 0, 0, 8'h00);
        push(1, 0, 0, 0, 0, 0, 0, 0, 8'h00);
        // default raster, first line
        push(0, 1,   1,   0, 0, 0, 0, 0, 8'h96);
        push(0, 256, 256, 0, 0, 0, 0, 0, 8'h96);
        push(0, 257, 257, 0, 1, 0, 0, 0, 8'h96);
        push(0, 288, 288, 0, 1, 0, 0, 0, 8'h96);
        push(0, 289, 289, 0, 1, 0, 1, 0, 8'h96);
        push(0, 320, 320, 0, 1, 0, 1, 0, 8'h96);
        push(0, 321, 321, 0, 1, 0, 0, 0, 8'h96);
        push(0, 384, 0,   1, 1, 0, 0, 0, 8'h96);
        push(0, 385, 1,   1, 0, 0, 0, 0, 8'h96);
        // small raster, frame 0 (offsets still 0)
        push(1, 1,    1,  0,  0, 0, 0, 0, 8'h96);
        push(1, 32,   32, 0,  0, 0, 0, 0, 8'h96);
        push(1, 33,   33, 0,  1, 0, 0, 0, 8'h96);
        push(1, 44,   44, 0,  1, 0, 0, 0, 8'h96);
        push(1, 45,   45, 0,  1, 0, 1, 0, 8'h96);
        push(1, 52,   52, 0,  1, 0, 1, 0, 8'h96);
        push(1, 53,   53, 0,  1, 0, 0, 0, 8'h96);
        push(1, 64,   0,  1,  1, 0, 0, 0, 8'h96);
        push(1, 65,   1,  1,  0, 0, 0, 0, 8'h96);
        push(1, 1024, 0,  16, 1, 0, 0, 0, 8'h96);
        push(1, 1025, 1,  16, 0, 1, 0, 0, 8'h96);
        push(1, 1600, 0,  25, 1, 1, 0, 0, 8'h96);
        push(1, 1601, 1,  25, 0, 1, 0, 1, 8'h96);
        push(1, 1792, 0,  28, 1, 1, 0, 1, 8'h96);
        push(1, 1793, 1,  28, 0, 1, 0, 0, 8'h96);
        push(1, 2304, 0,  0,  1, 1, 0, 0, 8'hFF);
        // frame 1: HOFS=-8, VOFS=+2
        push(1, 2305, 1,  0,  0, 0, 0, 0, 8'hFF);
        push(1, 2340, 36, 0,  1, 0, 0, 0, 8'hFF);
        push(1, 2341, 37, 0,  1, 0, 1, 0, 8'hFF);
        push(1, 2348, 44, 0,  1, 0, 1, 0, 8'hFF);
        push(1, 2349, 45, 0,  1, 0, 0, 0, 8'hFF);
        push(1, 3109, 37, 12, 1, 0, 1, 0, 8'hFF);
        push(1, 4032, 0,  27, 1, 1, 0, 0, 8'hFF);
        push(1, 4033, 1,  27, 0, 1, 0, 1, 8'hFF);
        push(1, 4224, 0,  30, 1, 1, 0, 1, 8'hFF);
        push(1, 4225, 1,  30, 0, 1, 0, 0, 8'hFF);
        // frame 2: HOFS=+7 picked up at the wrap
        push(1, 4659, 51, 0,  1, 0, 0, 0, 8'hFF);
        push(1, 4660, 52, 0,  1, 0, 1, 0, 8'hFF);
        push(1, 4667, 59, 0,  1, 0, 1, 0, 8'hFF);
        push(1, 4668, 60, 0,  1, 0, 0, 0, 8'hFF);
        push(1, 4811, 11, 3,  0, 0, 0, 0, 8'hFF);
        repeat (5) @(negedge clk);
        #2 reset = 1'b0;
        repeat (8 * 2000) @(posedge clk);
        #2 POUT = 8'hFF;
        repeat (8 * (2944 - 2000)) @(posedge clk);
        #2 HOFS = 4'd7;
        repeat (8 * (4948 - 2944)) @(posedge clk);
        @(negedge clk);
        #2;
        push(0, 0, 0, 0, 0, 0, 0, 0, 8'h00);
        push(1, 0, 0, 0, 0, 0, 0, 0, 8'h00);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        foreach (sb[i]) begin
            n_vec++;
            n_fail++;
            $display("FAIL dut%0d_k%0d never_checked got=none exp=%h", sb[i].d, sb[i].k, sb[i].exp);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
